// File: rtl/cache_tag_pkg.sv
// Shared widths, tag-store entry and output-slot types for the cache tag-compare stage.
package cache_tag_pkg;

    localparam int BLK_X_WDTH   = 7;
    localparam int BLK_Y_WDTH   = 7;
    localparam int SET_X_BITS   = 2;
    localparam int SET_Y_BITS   = 3;
    localparam int NUM_WAYS     = 4;
    localparam int REF_IDX_WDTH = 4;

    localparam int SET_WDTH = SET_X_BITS + SET_Y_BITS;
    localparam int NUM_SETS = 1 << SET_WDTH;
    localparam int WAY_WDTH = $clog2(NUM_WAYS);
    localparam int TAG_WDTH = REF_IDX_WDTH + (BLK_Y_WDTH - SET_Y_BITS) + (BLK_X_WDTH - SET_X_BITS);

    typedef logic [SET_WDTH-1:0] set_t;
    typedef logic [WAY_WDTH-1:0] way_t;
    typedef logic [TAG_WDTH-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } tag_entry_t;

    typedef struct packed {
        logic                    hit;
        set_t                    set;
        way_t                    way;
        logic                    changed_luma;
        logic                    changed_chma;
        logic [BLK_X_WDTH-1:0]   x;
        logic [BLK_Y_WDTH-1:0]   y;
        logic [REF_IDX_WDTH-1:0] ref_idx;
    } tag_result_t;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_FLUSH  = 1'b1
    } tag_state_t;

    function automatic set_t get_set(input logic [BLK_X_WDTH-1:0] x,
                                     input logic [BLK_Y_WDTH-1:0] y);
        return {y[SET_Y_BITS-1:0], x[SET_X_BITS-1:0]};
    endfunction

    function automatic tag_t get_tag(input logic [BLK_X_WDTH-1:0]   x,
                                     input logic [BLK_Y_WDTH-1:0]   y,
                                     input logic [REF_IDX_WDTH-1:0] ref_idx);
        return {ref_idx, y[BLK_Y_WDTH-1:SET_Y_BITS], x[BLK_X_WDTH-1:SET_X_BITS]};
    endfunction

endpackage

// File: rtl/cache_tag_way_select.sv
// Combinational hit detection and victim-way choice for one set of the tag store.
module cache_tag_way_select
    import cache_tag_pkg::*;
(
    input  tag_entry_t [NUM_WAYS-1:0] entries,
    input  tag_t                      lookup_tag,
    input  way_t                      victim_ptr,
    output logic                      hit,
    output way_t                      hit_way,
    output way_t                      alloc_way,
    output logic                      use_victim
);

    // Scanning downwards lets the lowest matching / lowest invalid way win.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        alloc_way  = victim_ptr;
        use_victim = 1'b1;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (entries[i].valid && (entries[i].tag == lookup_tag)) begin
                hit     = 1'b1;
                hit_way = way_t'(i);
            end
            if (!entries[i].valid) begin
                alloc_way  = way_t'(i);
                use_victim = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_tag_compare.sv
// Tag lookup/allocation stage: one-entry output slot feeding independent data and miss channels.
//   state     | meaning
//   ST_ACTIVE | lookups accepted, tag store updated on misses
//   ST_FLUSH  | one cycle clearing all valid bits and victim pointers
module cache_tag_compare
    import cache_tag_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_input_stage_valid,
    output logic                    tag_compare_stage_ready,
    input  logic [BLK_X_WDTH-1:0]   curr_x_addr,
    input  logic [BLK_Y_WDTH-1:0]   curr_y_addr,
    input  logic [REF_IDX_WDTH-1:0] ref_idx_in,
    input  logic                    cur_xy_changed_luma,
    input  logic                    cur_xy_changed_chma,
    input  logic                    flush_in,
    output logic                    tag_out_valid,
    input  logic                    tag_out_ready,
    output logic                    tag_out_hit,
    output logic [SET_WDTH-1:0]     tag_out_set,
    output logic [WAY_WDTH-1:0]     tag_out_way,
    output logic                    tag_out_changed_luma,
    output logic                    tag_out_changed_chma,
    output logic                    miss_req_valid,
    input  logic                    miss_req_ready,
    output logic [BLK_X_WDTH-1:0]   miss_req_x,
    output logic [BLK_Y_WDTH-1:0]   miss_req_y,
    output logic [REF_IDX_WDTH-1:0] miss_req_ref,
    output logic [SET_WDTH-1:0]     miss_req_set,
    output logic [WAY_WDTH-1:0]     miss_req_way
);

    tag_state_t state, state_nxt;

    tag_entry_t [NUM_WAYS-1:0] store  [NUM_SETS];
    way_t                      victim [NUM_SETS];

    tag_result_t slot;
    logic        data_pend;
    logic        miss_pend;

    set_t lk_set;
    tag_t lk_tag;
    logic lk_hit;
    way_t lk_hit_way;
    way_t lk_alloc_way;
    logic lk_use_victim;
    way_t lk_way;

    logic retire;
    logic accept;

    assign lk_set = get_set(curr_x_addr, curr_y_addr);
    assign lk_tag = get_tag(curr_x_addr, curr_y_addr, ref_idx_in);

    cache_tag_way_select u_way_select (
        .entries    (store[lk_set]),
        .lookup_tag (lk_tag),
        .victim_ptr (victim[lk_set]),
        .hit        (lk_hit),
        .hit_way    (lk_hit_way),
        .alloc_way  (lk_alloc_way),
        .use_victim (lk_use_victim)
    );

    assign lk_way = lk_hit ? lk_hit_way : lk_alloc_way;

    assign retire = (~data_pend | tag_out_ready) & (~miss_pend | miss_req_ready);
    assign tag_compare_stage_ready = (state == ST_ACTIVE) & ~flush_in & retire;
    assign accept = set_input_stage_valid & tag_compare_stage_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACTIVE: if (flush_in) state_nxt = ST_FLUSH;
            ST_FLUSH:  state_nxt = flush_in ? ST_FLUSH : ST_ACTIVE;
            default:   state_nxt = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_ACTIVE;
        else       state <= state_nxt;
    end

    // The registered store already reflects a miss allocation for the next lookup, so no bypass.
    always_ff @(posedge clk) begin
        if (reset || (state == ST_FLUSH)) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                store[s]  <= '0;
                victim[s] <= '0;
            end
        end else if (accept && !lk_hit) begin
            store[lk_set][lk_alloc_way] <= '{valid: 1'b1, tag: lk_tag};
            if (lk_use_victim) victim[lk_set] <= victim[lk_set] + way_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot      <= '0;
            data_pend <= 1'b0;
            miss_pend <= 1'b0;
        end else if (accept) begin
            data_pend         <= 1'b1;
            miss_pend         <= ~lk_hit;
            slot.hit          <= lk_hit;
            slot.set          <= lk_set;
            slot.way          <= lk_way;
            slot.changed_luma <= cur_xy_changed_luma;
            slot.changed_chma <= cur_xy_changed_chma;
            slot.x            <= curr_x_addr;
            slot.y            <= curr_y_addr;
            slot.ref_idx      <= ref_idx_in;
        end else begin
            if (tag_out_ready)  data_pend <= 1'b0;
            if (miss_req_ready) miss_pend <= 1'b0;
        end
    end

    assign tag_out_valid        = data_pend;
    assign tag_out_hit          = slot.hit;
    assign tag_out_set          = slot.set;
    assign tag_out_way          = slot.way;
    assign tag_out_changed_luma = slot.changed_luma;
    assign tag_out_changed_chma = slot.changed_chma;

    assign miss_req_valid = miss_pend;
    assign miss_req_x     = slot.x;
    assign miss_req_y     = slot.y;
    assign miss_req_ref   = slot.ref_idx;
    assign miss_req_set   = slot.set;
    assign miss_req_way   = slot.way;

endmodule

// File: tb/tb_cache_tag_compare.sv
// Scoreboard bench for cache_tag_compare against a plain set-associative cache model.
module tb_cache_tag_compare;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic       ready;
    logic [6:0] cx = '0;
    logic [6:0] cy = '0;
    logic [3:0] cref = '0;
    logic       cl = 1'b0;
    logic       cc = 1'b0;
    logic       flush_in = 1'b0;
    logic       tag_out_valid;
    logic       d_rdy = 1'b1;
    logic       tag_out_hit;
    logic [4:0] tag_out_set;
    logic [1:0] tag_out_way;
    logic       tag_out_changed_luma;
    logic       tag_out_changed_chma;
    logic       miss_req_valid;
    logic       m_rdy = 1'b1;
    logic [6:0] miss_req_x;
    logic [6:0] miss_req_y;
    logic [3:0] miss_req_ref;
    logic [4:0] miss_req_set;
    logic [1:0] miss_req_way;

    cache_tag_compare dut (
        .clk                     (clk),
        .reset                   (reset),
        .set_input_stage_valid   (valid),
        .tag_compare_stage_ready (ready),
        .curr_x_addr             (cx),
        .curr_y_addr             (cy),
        .ref_idx_in              (cref),
        .cur_xy_changed_luma     (cl),
        .cur_xy_changed_chma     (cc),
        .flush_in                (flush_in),
        .tag_out_valid           (tag_out_valid),
        .tag_out_ready           (d_rdy),
        .tag_out_hit             (tag_out_hit),
        .tag_out_set             (tag_out_set),
        .tag_out_way             (tag_out_way),
        .tag_out_changed_luma    (tag_out_changed_luma),
        .tag_out_changed_chma    (tag_out_changed_chma),
        .miss_req_valid          (miss_req_valid),
        .miss_req_ready          (m_rdy),
        .miss_req_x              (miss_req_x),
        .miss_req_y              (miss_req_y),
        .miss_req_ref            (miss_req_ref),
        .miss_req_set            (miss_req_set),
        .miss_req_way            (miss_req_way)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int hit; int set; int way; int luma; int chma;
        int x; int y; int r; int acc;
    } exp_t;

    exp_t data_q[$];
    exp_t miss_q[$];

    // Cache model: 32 sets x 4 ways, round-robin pointer per set.
    int mv[32][4];
    int mt[32][4];
    int mp[32];

    bit rand_rdy = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 32; s++) begin
            mp[s] = 0;
            for (int w = 0; w < 4; w++) begin
                mv[s][w] = 0;
                mt[s][w] = 0;
            end
        end
    endtask

    task automatic model_issue(input int x, input int y, input int r, input int l, input int c);
        exp_t e2;
        int s, t, w, h;
        s = (y % 8) * 4 + (x % 4);
        t = r * 512 + (y / 8) * 32 + (x / 4);
        h = 0;
        w = -1;
        for (int i = 0; i < 4; i++)
            if (h == 0 && mv[s][i] != 0 && mt[s][i] == t) begin h = 1; w = i; end
        if (h == 0) begin
            for (int i = 0; i < 4; i++)
                if (w < 0 && mv[s][i] == 0) w = i;
            if (w < 0) begin
                w = mp[s];
                mp[s] = (mp[s] + 1) % 4;
            end
            mv[s][w] = 1;
            mt[s][w] = t;
        end
        e2.hit = h; e2.set = s; e2.way = w; e2.luma = l; e2.chma = c;
        e2.x = x; e2.y = y; e2.r = r; e2.acc = cyc;
        data_q.push_back(e2);
        if (h == 0) miss_q.push_back(e2);
    endtask

    task automatic send(input int x, input int y, input int r, input int l, input int c,
                        input int mr, output int waits);
        bit got;
        got = 1'b0;
        waits = 0;
        @(negedge clk);
        valid = 1'b1;
        cx = 7'(x); cy = 7'(y); cref = 4'(r); cl = (l != 0); cc = (c != 0);
        if (mr >= 0) m_rdy = (mr != 0);
        for (int t = 0; t < 200 && !got; t++) begin
            #4;
            if (ready) begin
                model_issue(x, y, r, l, c);
                got = 1'b1;
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        valid = 1'b0;
        flush_in = 1'b1;
        model_clear();
        @(negedge clk);
        flush_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rand_rdy) begin
            d_rdy = ($urandom_range(0, 3) != 0);
            m_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares the queue heads every cycle a channel presents, pops on handshake.
    bit   dchk = 1'b0;
    bit   mchk = 1'b0;
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                dchk = 1'b0;
                mchk = 1'b0;
            end else begin
                if (tag_out_valid) begin
                    if (data_q.size() == 0) chk("data_unexpected", 1, 0);
                    else begin
                        e = data_q[0];
                        if (!dchk) begin chk("data_latency", cyc - e.acc, 1); dchk = 1'b1; end
                        chk("data_hit",  int'(tag_out_hit), e.hit);
                        chk("data_set",  int'(tag_out_set), e.set);
                        chk("data_way",  int'(tag_out_way), e.way);
                        chk("data_luma", int'(tag_out_changed_luma), e.luma);
                        chk("data_chma", int'(tag_out_changed_chma), e.chma);
                        if (d_rdy) begin void'(data_q.pop_front()); dchk = 1'b0; end
                    end
                end
                if (miss_req_valid) begin
                    if (miss_q.size() == 0) chk("miss_unexpected", 1, 0);
                    else begin
                        e = miss_q[0];
                        if (!mchk) begin chk("miss_latency", cyc - e.acc, 1); mchk = 1'b1; end
                        chk("miss_x",   int'(miss_req_x), e.x);
                        chk("miss_y",   int'(miss_req_y), e.y);
                        chk("miss_ref", int'(miss_req_ref), e.r);
                        chk("miss_set", int'(miss_req_set), e.set);
                        chk("miss_way", int'(miss_req_way), e.way);
                        if (m_rdy) begin void'(miss_q.pop_front()); mchk = 1'b0; end
                    end
                end
            end
        end
    end

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_tag_valid"},  int'(tag_out_valid), 0);
        chk({pfx, "_miss_valid"}, int'(miss_req_valid), 0);
        chk({pfx, "_hit"},        int'(tag_out_hit), 0);
        chk({pfx, "_set"},        int'(tag_out_set), 0);
        chk({pfx, "_way"},        int'(tag_out_way), 0);
        chk({pfx, "_luma"},       int'(tag_out_changed_luma), 0);
        chk({pfx, "_chma"},       int'(tag_out_changed_chma), 0);
        chk({pfx, "_mx"},         int'(miss_req_x), 0);
        chk({pfx, "_my"},         int'(miss_req_y), 0);
        chk({pfx, "_mref"},       int'(miss_req_ref), 0);
        chk({pfx, "_mset"},       int'(miss_req_set), 0);
        chk({pfx, "_mway"},       int'(miss_req_way), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        model_clear();
        repeat (3) @(negedge clk);
        #4;
        chk_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        #4;
        chk("reset_ready", int'(ready), 1);

        // Basic miss / hit / ref-index distinction in set 5.
        send(5, 9, 0, 1, 0, -1, w);
        send(5, 9, 0, 0, 1, -1, w);
        send(5, 9, 1, 1, 1, -1, w);
        idle();

        // Five tags into set 0 wrap the victim pointer; x=0 was evicted.
        for (int i = 0; i < 5; i++) send(i * 4, 0, 0, i % 2, 0, -1, w);
        send(0, 0, 0, 0, 0, -1, w);
        idle();

        // Full throughput.
        for (int i = 0; i < 8; i++) begin
            send(40 + i, 17 + i, 3, i % 2, (i / 2) % 2, -1, w);
            chk("b2b_ready", w, 0);
        end
        idle();

        // Miss channel stalled for three cycles.
        @(negedge clk);
        d_rdy = 1'b1;
        send(30, 30, 2, 1, 0, 0, w);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid = 1'b1;
            cx = 7'd31; cy = 7'd30; cref = 4'd2; cl = 1'b0; cc = 1'b1;
            #4;
            chk("stall_ready", int'(ready), 0);
            chk("stall_miss_valid", int'(miss_req_valid), 1);
            chk("stall_tag_valid", int'(tag_out_valid), (k == 0) ? 1 : 0);
        end
        send(31, 30, 2, 0, 1, 1, w);
        chk("accept_on_release", w, 0);
        idle();

        // Flush with a pending hit result.
        @(negedge clk);
        d_rdy = 1'b0;
        send(5, 9, 0, 1, 1, -1, w);
        @(negedge clk);
        valid = 1'b0;
        flush_in = 1'b1;
        model_clear();
        #4;
        chk("flush_ready_pulse", int'(ready), 0);
        @(negedge clk);
        flush_in = 1'b0;
        d_rdy = 1'b1;
        #4;
        chk("flush_ready_state", int'(ready), 0);
        @(negedge clk);
        #4;
        chk("flush_ready_after", int'(ready), 1);
        chk("flush_drained", data_q.size(), 0);
        send(5, 9, 0, 0, 0, -1, w);
        idle();

        // Reset while a result is held.
        @(negedge clk);
        d_rdy = 1'b0;
        send(5, 9, 0, 1, 0, -1, w);
        @(negedge clk);
        valid = 1'b0;
        #4;
        chk("rst_pre_valid", int'(tag_out_valid), 1);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        data_q.delete();
        miss_q.delete();
        @(negedge clk);
        #4;
        chk_outputs_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        d_rdy = 1'b1;
        send(5, 9, 0, 1, 0, -1, w);
        idle();

        // Randomized traffic with random back-pressure and occasional flushes.
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) do_flush();
            else if (r < 4) idle();
            else send(int'($urandom_range(0, 11)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), -1, w);
        end
        @(negedge clk);
        rand_rdy = 1'b0;
        valid = 1'b0;
        d_rdy = 1'b1;
        m_rdy = 1'b1;
        repeat (5) @(negedge clk);
        #4;
        chk("drain_data_q", data_q.size(), 0);
        chk("drain_miss_q", miss_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_tag_compare.md
Name: cache_tag_compare

Overview:
- Stage directly downstream of the cache set-input stage.
- Takes one cache-block coordinate per handshake: block-granular x/y address plus sideband.
- Splits each coordinate into set index and tag, looks it up in a register-based set-associative tag store, and allocates a victim way on a miss (round-robin).
- Emits a hit/miss result towards the data stage and an independent miss request towards the AXI fetch side.

Parameters:
- BLK_X_WDTH, 7, width of the block x address (X_ADDR_WDTH - C_L_H_SIZE)
- BLK_Y_WDTH, 7, width of the block y address (Y_ADDR_WDTH - C_L_V_SIZE)
- SET_X_BITS, 2, low x-address bits used in the set index
- SET_Y_BITS, 3, low y-address bits used in the set index
- NUM_WAYS, 4, associativity; power of two, 2..8
- REF_IDX_WDTH, 4, reference-picture index width; this index is part of the tag

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- set_input_stage_valid  in  1  upstream entry valid
- tag_compare_stage_ready  out  1  this stage accepts an entry this cycle
- curr_x_addr  in  BLK_X_WDTH  block x address
- curr_y_addr  in  BLK_Y_WDTH  block y address
- ref_idx_in  in  REF_IDX_WDTH  reference picture of the block
- cur_xy_changed_luma  in  1  sideband, passed through
- cur_xy_changed_chma  in  1  sideband, passed through
- flush_in  in  1  one-cycle pulse; invalidate the whole tag store
- tag_out_valid  out  1  result valid towards the data stage
- tag_out_ready  in  1  data stage accepts
- tag_out_hit  out  1  1 = hit, 0 = miss
- tag_out_set  out  SET_X_BITS+SET_Y_BITS  set index
- tag_out_way  out  log2(NUM_WAYS)  hit way or allocated way
- tag_out_changed_luma  out  1  registered copy of the luma sideband
- tag_out_changed_chma  out  1  registered copy of the chroma sideband
- miss_req_valid  out  1  fetch request valid
- miss_req_ready  in  1  fetch side accepts
- miss_req_x  out  BLK_X_WDTH  block x address to fetch
- miss_req_y  out  BLK_Y_WDTH  block y address to fetch
- miss_req_ref  out  REF_IDX_WDTH  reference index to fetch
- miss_req_set  out  SET_X_BITS+SET_Y_BITS  destination set
- miss_req_way  out  log2(NUM_WAYS)  destination way

Behaviour:
- Address split:
  - set = {curr_y_addr[SET_Y_BITS-1:0], curr_x_addr[SET_X_BITS-1:0]}
  - tag = {ref_idx_in, curr_y_addr[BLK_Y_WDTH-1:SET_Y_BITS], curr_x_addr[BLK_X_WDTH-1:SET_X_BITS]}
  - NUM_SETS = 2^(SET_X_BITS+SET_Y_BITS).
- Tag store:
  - Per set and way: valid bit and tag.
  - Per set: a round-robin victim pointer, log2(NUM_WAYS) bits.
- Lookup:
  - Combinational compare of the input against all ways of the indexed set.
  - At most one way can match; the lowest matching index wins if that invariant is violated.
- States: ACTIVE, FLUSH.
  - ACTIVE -> FLUSH when flush_in=1.
  - FLUSH -> ACTIVE after exactly one cycle. That FLUSH cycle clears every valid bit and every victim pointer.
  - tag_compare_stage_ready=0 in FLUSH and in the cycle flush_in is high.
  - flush_in arriving while in FLUSH extends FLUSH by one cycle.
- Output slot:
  - One register holds the result and two flags: data_pend and miss_pend.
  - Accept = set_input_stage_valid & tag_compare_stage_ready.
  - tag_compare_stage_ready = state==ACTIVE & ~flush_in & (slot empty | slot retiring this cycle), giving full throughput.
  - Slot retires when (~data_pend | tag_out_ready) & (~miss_pend | miss_req_ready).
  - tag_out_valid = data_pend; miss_req_valid = miss_pend. The two channels complete independently in any order.
- On accept, the slot loads:
  - data_pend=1 and miss_pend=~hit.
  - Set, way, sideband, and the address/ref for the miss request.
- On accept with a hit: the tag store is unchanged.
- On accept with a miss:
  - The way is the first invalid way of the set; if there is none, the victim pointer.
  - The way is written with valid=1 and the new tag in the same clock edge.
  - The victim pointer increments modulo NUM_WAYS only when the victim pointer was used.
- Back-to-back accesses to the same block: the second sees the allocated way and reports a hit. There is no bypass path; the registered store already reflects the first access.
- Latency: one cycle from accept to tag_out_valid / miss_req_valid.
- Flush and the slot: an entry already in the slot still drains normally.
- Reset values:
  - tag_out_valid=0, miss_req_valid=0, tag_out_hit=0, set/way=0, sideband outputs=0, miss address fields=0.
  - All valid bits=0, victim pointers=0, state=ACTIVE.
- Reset mid-transfer drops the slot contents with no handshake.

Decomposition:
- Shared package cache_tag_pkg:
  - constants NUM_SETS, SET_WDTH, WAY_WDTH, TAG_WDTH
  - typedef tag_entry_t {valid, tag}
  - typedef tag_result_t for the output-slot contents
- One sub-module, cache_tag_way_select, purely combinational. Inputs: the set's entries, the lookup tag, the victim pointer. Outputs: hit, hit_way, alloc_way, use_victim.

Test Plan:
1. After reset, three accepts: (x=5, y=9, ref=0), then the same coordinate, then (x=5, y=9, ref=1) -> miss way0 with miss_req x=5 y=9 set=0x05; then hit way0; then miss way1 with ref=1. Every tag_out_valid appears one cycle after its accept.
2. Five distinct tags into set 0 (x = 0, 4, 8, 12, 16; y=0) -> misses allocate ways 0, 1, 2, 3, then 0 again (victim pointer). A re-access of x=0 then misses.
3. Back-to-back valid for 8 cycles, with tag_out_ready and miss_req_ready held at 1 -> tag_compare_stage_ready stays 1 and eight results arrive on consecutive cycles.
4. A miss while miss_req_ready=0 for 3 cycles and tag_out_ready=1 -> the data result is taken on the first cycle, miss_req_valid is held with stable fields, and ready stays 0 until miss_req_ready rises; the next entry is accepted in that same cycle.
5. flush_in pulse with a result pending -> ready=0 for 2 cycles and the pending result still delivered; a re-access of a previously hit block then reports a miss at way0.
6. reset asserted while tag_out_valid=1 and tag_out_ready=0 -> on the next cycle all outputs are 0 and a subsequent access misses.
